// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner.
// One digit is lit per slot of TICK_DIV clocks, cycling through N_DIGITS.
// Display content comes from shadow registers that reload once per frame,
// so the input bus may change at any time without tearing a frame.
// Digit blanking, leading-zero suppression and an optional hex glyph set
// are supported. All display outputs are registered.

module seven_seg_scanner #(
   parameter int N_DIGITS = 4,        // legal range 2..8
   parameter int TICK_DIV = 100000,   // clk cycles per digit slot, >= 2
   parameter bit HEX_MODE = 1'b1      // 1: draw A-F glyphs, 0: blank nibbles > 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [4*N_DIGITS-1:0]   data,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     blank_in,
   input  logic                    lz_suppress,
   output logic [N_DIGITS-1:0]     an,
   output logic [6:0]              sseg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [6:0]       SEG_OFF  = 7'h7F;

   // Scan state
   logic [CNT_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  first_q;   // set by reset until the first enabled clock

   // Shadow copy of the display inputs, reloaded once per frame
   logic [4*N_DIGITS-1:0] data_q;
   logic [N_DIGITS-1:0]   dp_sh_q;
   logic [N_DIGITS-1:0]   blank_q;
   logic                  lz_q;

   // Registered outputs
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic [6:0]            sseg_q, sseg_d;
   logic                  dp_q, dp_d;
   logic                  fs_q;

   // Combinational helpers
   logic                  tick;
   logic                  load;
   logic [N_DIGITS-1:0]   lz_mask;
   logic [3:0]            cur_nib;

   // Active-low glyph for one nibble; a = bit 6.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = HEX_MODE ? 7'b0001000 : SEG_OFF;
         4'hB: g = HEX_MODE ? 7'b1100000 : SEG_OFF;
         4'hC: g = HEX_MODE ? 7'b0110001 : SEG_OFF;
         4'hD: g = HEX_MODE ? 7'b1000010 : SEG_OFF;
         4'hE: g = HEX_MODE ? 7'b0110000 : SEG_OFF;
         default: g = HEX_MODE ? 7'b0111000 : SEG_OFF;
      endcase
      return g;
   endfunction

   // Next scan state, shadow load strobe and next display drive
   always_comb begin
      logic zero_run;
      // NOTE: every signal written here gets a default first, so no path
      // through the block can leave one unassigned and infer a latch.
      presc_d  = presc_q;
      idx_d    = idx_q;
      lz_mask  = '0;
      an_d     = '1;
      sseg_d   = SEG_OFF;
      dp_d     = 1'b1;
      zero_run = 1'b1;

      tick = (presc_q == CNT_LAST);
      load = enable && (first_q || (tick && (idx_q == IDX_LAST)));

      if (enable) begin
         presc_d = tick ? '0 : presc_q + CNT_W'(1);
         if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end
      end

      // A digit is a leading zero when it and every digit above it is zero;
      // digit 0 always shows.
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (data_q[4*k +: 4] == 4'h0);
         if (k != 0) begin
            lz_mask[k] = zero_run;
         end
      end

      cur_nib = data_q[4*idx_q +: 4];

      // Blanked digits keep their anode off; lz-blanked digits keep the anode
      // on so their decimal point can still light.
      if (enable && !blank_q[idx_q]) begin
         an_d[idx_q] = 1'b0;
         dp_d        = ~dp_sh_q[idx_q];
         sseg_d      = (lz_q && lz_mask[idx_q]) ? SEG_OFF : glyph(cur_nib);
      end
   end

   // Scan counters, shadow registers and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= '0;
         first_q <= 1'b1;
         // NOTE: the shadow registers are reset as well, so the display shows
         // a defined all-zero image until the first load.
         data_q  <= '0;
         dp_sh_q <= '0;
         blank_q <= '0;
         lz_q    <= 1'b0;
         an_q    <= '1;
         sseg_q  <= SEG_OFF;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         presc_q <= presc_d;
         idx_q   <= idx_d;
         if (enable) begin
            first_q <= 1'b0;
         end
         if (load) begin
            data_q  <= data;
            dp_sh_q <= dp_in;
            blank_q <= blank_in;
            lz_q    <= lz_suppress;
         end
         an_q   <= an_d;
         sseg_q <= sseg_d;
         dp_q   <= dp_d;
         fs_q   <= load;
      end
   end

   assign an          = an_q;
   assign sseg        = sseg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: N_DIGITS=4, TICK_DIV=4.
// A second instance with HEX_MODE=0 shares the stimulus.
// Edge numbers in comments count clk edges from the first enabled edge
// after the initial reset release.

module tb_seven_seg_scanner;

   localparam logic [6:0] G0   = 7'b0000001;
   localparam logic [6:0] G1   = 7'b1001111;
   localparam logic [6:0] G2   = 7'b0010010;
   localparam logic [6:0] G3   = 7'b0000110;
   localparam logic [6:0] G4   = 7'b1001100;
   localparam logic [6:0] GA   = 7'b0001000;
   localparam logic [6:0] GB   = 7'b1100000;
   localparam logic [6:0] GF   = 7'b0111000;
   localparam logic [6:0] OFF  = 7'h7F;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_suppress;

   logic [3:0]  an,  an_h0;
   logic [6:0]  sseg, sseg_h0;
   logic        dp,  dp_h0;
   logic        fs,  fs_h0;

   int checks   = 0;
   int failures = 0;

   seven_seg_scanner #(.N_DIGITS(4), .TICK_DIV(4), .HEX_MODE(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .data        (data),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_suppress (lz_suppress),
      .an          (an),
      .sseg        (sseg),
      .dp          (dp),
      .frame_start (fs)
   );

   seven_seg_scanner #(.N_DIGITS(4), .TICK_DIV(4), .HEX_MODE(1'b0)) dut_dec (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .data        (data),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_suppress (lz_suppress),
      .an          (an_h0),
      .sseg        (sseg_h0),
      .dp          (dp_h0),
      .frame_start (fs_h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      data        = 16'h0000;
      dp_in       = 4'b0000;
      blank_in    = 4'b0000;
      lz_suppress = 1'b0;

      // Reset state
      #2;
      check("rst_an",   {12'h0, an},   16'h000F);
      check("rst_sseg", {9'h0, sseg},  {9'h0, OFF});
      check("rst_dp",   {15'h0, dp},   16'h0001);
      check("rst_fs",   {15'h0, fs},   16'h0000);

      step(2);
      reset  = 1'b0;
      enable = 1'b1;
      data   = 16'h12AF;

      // Basic scan of 12AF
      step(1);   // edge 1: first enabled clock loads shadow
      check("first_fs", {15'h0, fs}, 16'h0001);
      step(1);   // edge 2
      check("fs_low",   {15'h0, fs},   16'h0000);
      check("d0_an",    {12'h0, an},   16'h000E);
      check("d0_sseg",  {9'h0, sseg},  {9'h0, GF});
      check("d0_dp",    {15'h0, dp},   16'h0001);
      step(4);   // edge 6
      check("d1_an",    {12'h0, an},   16'h000D);
      check("d1_sseg",  {9'h0, sseg},  {9'h0, GA});
      step(4);   // edge 10
      check("d2_an",    {12'h0, an},   16'h000B);
      check("d2_sseg",  {9'h0, sseg},  {9'h0, G2});
      step(4);   // edge 14
      check("d3_an",    {12'h0, an},   16'h0007);
      check("d3_sseg",  {9'h0, sseg},  {9'h0, G1});
      step(2);   // edge 16: end-of-frame load
      check("frame2_fs", {15'h0, fs}, 16'h0001);
      step(1);   // edge 17
      check("frame2_fs_low", {15'h0, fs}, 16'h0000);
      check("wrap_an",   {12'h0, an},   16'h000E);
      check("wrap_sseg", {9'h0, sseg},  {9'h0, GF});

      // Mid-frame data change does not tear the frame
      data = 16'h1111;
      step(15);  // edge 32: 1111 loaded
      check("f3_fs", {15'h0, fs}, 16'h0001);
      step(6);   // edge 38: digit 1
      check("mid_d1_sseg", {9'h0, sseg}, {9'h0, G1});
      data = 16'h2222;
      step(4);   // edge 42: digit 2, still old shadow
      check("mid_d2_an",   {12'h0, an},  16'h000B);
      check("mid_d2_sseg", {9'h0, sseg}, {9'h0, G1});
      step(4);   // edge 46: digit 3, still old shadow
      check("mid_d3_sseg", {9'h0, sseg}, {9'h0, G1});
      step(2);   // edge 48: 2222 loaded
      check("f4_fs", {15'h0, fs}, 16'h0001);
      step(2);   // edge 50
      check("new_d0_sseg", {9'h0, sseg}, {9'h0, G2});

      // Leading-zero suppression on 0040, dp requested on digit 2
      data        = 16'h0040;
      lz_suppress = 1'b1;
      dp_in       = 4'b0100;
      step(14);  // edge 64: loaded
      check("lz_fs", {15'h0, fs}, 16'h0001);
      step(2);   // edge 66
      check("lz_d0_an",   {12'h0, an},  16'h000E);
      check("lz_d0_sseg", {9'h0, sseg}, {9'h0, G0});
      check("lz_d0_dp",   {15'h0, dp},  16'h0001);
      step(4);   // edge 70
      check("lz_d1_sseg", {9'h0, sseg}, {9'h0, G4});
      step(4);   // edge 74: lz-blanked, anode on, dp lit
      check("lz_d2_an",   {12'h0, an},  16'h000B);
      check("lz_d2_sseg", {9'h0, sseg}, {9'h0, OFF});
      check("lz_d2_dp",   {15'h0, dp},  16'h0000);
      step(4);   // edge 78
      check("lz_d3_an",   {12'h0, an},  16'h0007);
      check("lz_d3_sseg", {9'h0, sseg}, {9'h0, OFF});

      // Enable dropped during slot 2
      data        = 16'h3210;
      lz_suppress = 1'b0;
      dp_in       = 4'b0000;
      step(2);   // edge 80: loaded
      check("en_fs", {15'h0, fs}, 16'h0001);
      step(10);  // edge 90: slot 2
      check("pre_dis_an",   {12'h0, an},  16'h000B);
      check("pre_dis_sseg", {9'h0, sseg}, {9'h0, G2});
      enable = 1'b0;
      step(1);   // edge 91: dark
      check("dis_an",   {12'h0, an},  16'h000F);
      check("dis_sseg", {9'h0, sseg}, {9'h0, OFF});
      check("dis_dp",   {15'h0, dp},  16'h0001);
      check("dis_fs",   {15'h0, fs},  16'h0000);
      step(9);   // edge 100: still dark
      check("dis_end_an", {12'h0, an}, 16'h000F);
      check("dis_end_fs", {15'h0, fs}, 16'h0000);
      enable = 1'b1;
      step(1);   // edge 101: resumes in slot 2
      check("res_d2_an",   {12'h0, an},  16'h000B);
      check("res_d2_sseg", {9'h0, sseg}, {9'h0, G2});
      step(2);   // edge 103: slot 3
      check("res_d3_an",   {12'h0, an},  16'h0007);
      check("res_d3_sseg", {9'h0, sseg}, {9'h0, G3});
      step(3);   // edge 106: frame reload
      check("res_fs", {15'h0, fs}, 16'h0001);
      step(1);   // edge 107: slot 0
      check("res_d0_an",   {12'h0, an},  16'h000E);
      check("res_d0_sseg", {9'h0, sseg}, {9'h0, G0});

      // Forced blank on digit 0 (dp request must not leak through)
      blank_in = 4'b0001;
      dp_in    = 4'b0001;
      step(15);  // edge 122: loaded
      check("blk_fs", {15'h0, fs}, 16'h0001);
      step(2);   // edge 124
      check("blk_d0_an",   {12'h0, an},  16'h000F);
      check("blk_d0_sseg", {9'h0, sseg}, {9'h0, OFF});
      check("blk_d0_dp",   {15'h0, dp},  16'h0001);
      step(4);   // edge 128
      check("blk_d1_an",   {12'h0, an},  16'h000D);
      check("blk_d1_sseg", {9'h0, sseg}, {9'h0, G1});
      check("blk_d1_dp",   {15'h0, dp},  16'h0001);

      // Nibble B in hex and decimal builds, dp on digit 0
      blank_in = 4'b0000;
      dp_in    = 4'b0001;
      data     = 16'h000B;
      step(10);  // edge 138: loaded
      check("hex_fs", {15'h0, fs}, 16'h0001);
      step(2);   // edge 140
      check("hex_an",    {12'h0, an},      16'h000E);
      check("hex_sseg",  {9'h0, sseg},     {9'h0, GB});
      check("hex_dp",    {15'h0, dp},      16'h0000);
      check("dec_an",    {12'h0, an_h0},   16'h000E);
      check("dec_sseg",  {9'h0, sseg_h0},  {9'h0, OFF});
      check("dec_dp",    {15'h0, dp_h0},   16'h0000);

      // Asynchronous reset mid-slot, no clock edge
      #2;
      reset = 1'b1;
      #1;
      check("arst_an",   {12'h0, an},   16'h000F);
      check("arst_sseg", {9'h0, sseg},  {9'h0, OFF});
      check("arst_dp",   {15'h0, dp},   16'h0001);
      check("arst_fs",   {15'h0, fs},   16'h0000);
      reset = 1'b0;
      step(1);   // first enabled edge after release
      check("arst_first_fs", {15'h0, fs},   16'h0001);
      check("arst_first_an", {12'h0, an},   16'h000E);
      check("arst_first_sg", {9'h0, sseg},  {9'h0, G0});
      step(1);
      check("arst_reload_sg", {9'h0, sseg}, {9'h0, GB});
      check("arst_fs_low",    {15'h0, fs},  16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
